// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code conversion and width helper functions (no ports)
package gray_pkg;
  localparam int MAX_W = 32;
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [MAX_W-1:0] max_val(input int w);
    return w >= MAX_W ? '1 : (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/gray_codec.sv
// gray_codec: combinational converters; bin_i -> gray_o (binary to Gray), gray_i -> bin_o (Gray to binary)
module gray_codec
  import gray_pkg::*;
#(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] bin_i,
  input  logic [VEC_W-1:0] gray_i,
  output logic [VEC_W-1:0] gray_o,
  output logic [VEC_W-1:0] bin_o
);
  assign gray_o = VEC_W'(bin2gray(MAX_W'(bin_i)));
  assign bin_o  = VEC_W'(gray2bin(MAX_W'(gray_i)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down counter with binary (bin_o) and Gray (gray_o) outputs, load (load_i/load_gray_i/load_val_i), enable/direction (en_i/up_i), wrap/saturate pulse (wrap_o), sync active-low reset_n
module gray_counter
  import gray_pkg::*;
#(
  parameter int          VEC_W    = 4,
  parameter int          SATURATE = 0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic             load_gray_i,
  input  logic [VEC_W-1:0] load_val_i,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] gray_o,
  output logic             wrap_o
);
  localparam logic [VEC_W-1:0] MAX_B = VEC_W'(max_val(VEC_W));
  localparam logic [VEC_W-1:0] RST_B = VEC_W'(RST_VAL);
  localparam logic [VEC_W-1:0] RST_G = VEC_W'(bin2gray(MAX_W'(RST_B)));
  logic [VEC_W-1:0] bin_q, bin_d, gray_q, gray_d;
  logic [VEC_W-1:0] ld_bin, ld_gray, cur_bin, cnt_bin, cnt_gray;
  logic             wrap_q, wrap_d, term;
  gray_codec #(.VEC_W(VEC_W)) u_load (
    .bin_i (load_val_i),
    .gray_i(load_val_i),
    .gray_o(ld_gray),
    .bin_o (ld_bin)
  );
  // the step is taken from the decoded Gray register, which keeps Gray the authoritative pointer state
  gray_codec #(.VEC_W(VEC_W)) u_out (
    .bin_i (cnt_bin),
    .gray_i(gray_q),
    .gray_o(cnt_gray),
    .bin_o (cur_bin)
  );
  assign term    = up_i ? cur_bin == MAX_B : cur_bin == '0;
  assign cnt_bin = (SATURATE != 0 && term) ? cur_bin : up_i ? cur_bin + VEC_W'(1) : cur_bin - VEC_W'(1);
  always_comb begin
    bin_d  = load_i ? (load_gray_i ? ld_bin : load_val_i) : en_i ? cnt_bin : bin_q;
    gray_d = load_i ? (load_gray_i ? load_val_i : ld_gray) : en_i ? cnt_gray : gray_q;
    wrap_d = !load_i && en_i && term;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q  <= RST_B;
      gray_q <= RST_G;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end
  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign wrap_o = wrap_q;
endmodule
